// File: rtl/bus_fifo_slave.sv
// Memory-mapped 64-bit FIFO slave with status, clear, error counters and a
// fill-level threshold interrupt. Read data is combinational from current state.
module bus_fifo_slave #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int DW    = 64
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          s_sel,
   input  logic          s_wr,
   input  logic [15:0]   s_addr,
   input  logic [DW-1:0] s_din,
   output logic [DW-1:0] s_dout,
   output logic          irq
);

   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   localparam logic [7:0] OFF_DATA   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h01;
   localparam logic [7:0] OFF_CTRL   = 8'h02;
   localparam logic [7:0] OFF_ERR    = 8'h03;
   localparam logic [7:0] OFF_THRESH = 8'h04;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
   logic [AW:0]   count, count_nxt, thresh, thresh_nxt;
   logic [7:0]    ovf_cnt, udf_cnt, ovf_cnt_nxt, udf_cnt_nxt;
   logic          irq_nxt, push, empty, full;
   logic [7:0]    offset;
   logic          unused_addr_hi;

   assign offset         = s_addr[7:0];
   assign unused_addr_hi = ^s_addr[15:8];
   assign empty          = (count == '0);
   assign full           = (count == DEPTH_C);

   always_comb begin
      rd_ptr_nxt  = rd_ptr;
      wr_ptr_nxt  = wr_ptr;
      count_nxt   = count;
      ovf_cnt_nxt = ovf_cnt;
      udf_cnt_nxt = udf_cnt;
      thresh_nxt  = thresh;
      push        = 1'b0;
      if (s_sel) begin
         case (offset)
            OFF_DATA: begin
               if (s_wr) begin
                  if (full) begin
                     if (ovf_cnt != 8'hFF) ovf_cnt_nxt = ovf_cnt + 8'd1;
                  end else begin
                     push       = 1'b1;
                     wr_ptr_nxt = wr_ptr + PTR_ONE;
                     count_nxt  = count + CNT_ONE;
                  end
               end else begin
                  if (empty) begin
                     if (udf_cnt != 8'hFF) udf_cnt_nxt = udf_cnt + 8'd1;
                  end else begin
                     rd_ptr_nxt = rd_ptr + PTR_ONE;
                     count_nxt  = count - CNT_ONE;
                  end
               end
            end
            OFF_CTRL: begin
               if (s_wr && s_din[0]) begin
                  rd_ptr_nxt = '0;
                  wr_ptr_nxt = '0;
                  count_nxt  = '0;
               end
            end
            OFF_ERR: begin
               if (s_wr) begin
                  ovf_cnt_nxt = '0;
                  udf_cnt_nxt = '0;
               end
            end
            OFF_THRESH: begin
               if (s_wr) thresh_nxt = s_din[AW:0];
            end
            default: ;
         endcase
      end
      // irq is registered from next-state values so it tracks count with no lag
      irq_nxt = (thresh_nxt != '0) && (count_nxt >= thresh_nxt);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         ovf_cnt <= '0;
         udf_cnt <= '0;
         thresh  <= DEPTH_C;
         irq     <= 1'b0;
      end else begin
         rd_ptr  <= rd_ptr_nxt;
         wr_ptr  <= wr_ptr_nxt;
         count   <= count_nxt;
         ovf_cnt <= ovf_cnt_nxt;
         udf_cnt <= udf_cnt_nxt;
         thresh  <= thresh_nxt;
         irq     <= irq_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && push) mem[wr_ptr] <= s_din;
   end

   always_comb begin
      s_dout = '0;
      if (s_sel && !s_wr) begin
         case (offset)
            OFF_DATA: if (!empty) s_dout = mem[rd_ptr];
            OFF_STATUS: begin
               s_dout[0]      = empty;
               s_dout[1]      = full;
               s_dout[2]      = irq;
               s_dout[AW+8:8] = count;
            end
            OFF_ERR: begin
               s_dout[7:0]  = ovf_cnt;
               s_dout[15:8] = udf_cnt;
            end
            OFF_THRESH: s_dout[AW:0] = thresh;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Directed bench for bus_fifo_slave: reads queue their expected data, and a
// negedge monitor pops and compares whenever a read access is on the bus.
module tb_bus_fifo_slave;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        s_sel, s_wr;
   logic [15:0] s_addr;
   logic [63:0] s_din, s_dout;
   logic        irq;

   typedef struct {
      string       name;
      logic [63:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_run  = 0;
   int   n_fail = 0;

   bus_fifo_slave #(.DEPTH(8), .AW(3), .DW(64)) dut (
      .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr),
      .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && s_sel && !s_wr) begin
         if (exp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_read: got %h expected none (addr %h)", s_dout, s_addr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, s_dout, e.exp);
         end
      end
   end

   task automatic acc(input logic wr, input logic [15:0] addr, input logic [63:0] din);
      s_sel  = 1'b1;
      s_wr   = wr;
      s_addr = addr;
      s_din  = din;
      @(posedge clk);
      #1;
      s_sel  = 1'b0;
      s_wr   = 1'b0;
      s_addr = '0;
      s_din  = '0;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [63:0] din);
      acc(1'b1, addr, din);
   endtask

   task automatic rd(input logic [15:0] addr, input logic [63:0] exp, input string name);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      exp_q.push_back(e);
      acc(1'b0, addr, '0);
   endtask

   localparam logic [15:0] A_DATA   = 16'h0100;
   localparam logic [15:0] A_STATUS = 16'h0101;
   localparam logic [15:0] A_CTRL   = 16'h0102;
   localparam logic [15:0] A_ERR    = 16'h0103;
   localparam logic [15:0] A_THRESH = 16'h0104;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      s_sel   = 1'b0;
      s_wr    = 1'b0;
      s_addr  = '0;
      s_din   = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // reset state
      check("reset_irq", {63'd0, irq}, 64'h0);
      rd(A_STATUS, 64'h1, "reset_status");

      // basic order
      wr(A_DATA, 64'hA1);
      wr(A_DATA, 64'hB2);
      wr(A_DATA, 64'hC3);
      rd(A_STATUS, 64'h0300, "status_3");
      rd(A_DATA, 64'hA1, "pop_a1");
      rd(A_DATA, 64'hB2, "pop_b2");
      rd(A_DATA, 64'hC3, "pop_c3");
      rd(A_STATUS, 64'h1, "status_empty");

      // overflow / underflow with the threshold interrupt disabled
      wr(A_THRESH, 64'h0);
      for (int i = 1; i <= 9; i++) wr(A_DATA, 64'(i));
      rd(A_STATUS, 64'h0802, "status_full");
      rd(A_ERR, 64'h01, "err_ovf");
      for (int i = 1; i <= 8; i++) rd(A_DATA, 64'(i), "pop_full_seq");
      rd(A_DATA, 64'h0, "pop_empty");
      rd(A_ERR, 64'h0101, "err_ovf_udf");
      wr(A_ERR, 64'h0);
      rd(A_ERR, 64'h0, "err_cleared");
      wr(A_THRESH, 64'h8);

      // pointer wrap from a cleared FIFO
      wr(A_CTRL, 64'h1);
      for (int i = 0; i < 6; i++) wr(A_DATA, 64'(32 + i));
      for (int i = 0; i < 6; i++) rd(A_DATA, 64'(32 + i), "pop_prewrap");
      for (int i = 10; i <= 14; i++) wr(A_DATA, 64'(i));
      for (int i = 10; i <= 14; i++) rd(A_DATA, 64'(i), "pop_wrap");
      rd(A_STATUS, 64'h1, "status_after_wrap");

      // threshold interrupt and clear
      wr(A_THRESH, 64'h3);
      rd(A_THRESH, 64'h3, "thresh_rd");
      wr(A_DATA, 64'h51);
      wr(A_DATA, 64'h52);
      check("irq_below", {63'd0, irq}, 64'h0);
      wr(A_DATA, 64'h53);
      check("irq_at_thresh", {63'd0, irq}, 64'h1);
      rd(A_STATUS, 64'h0304, "status_irq");
      wr(A_CTRL, 64'h1);
      check("irq_after_clear", {63'd0, irq}, 64'h0);
      rd(A_THRESH, 64'h3, "thresh_kept");
      rd(A_STATUS, 64'h1, "status_cleared");
      for (int i = 0; i < 8; i++) wr(A_DATA, 64'(64 + i));
      check("irq_full", {63'd0, irq}, 64'h1);
      wr(A_THRESH, 64'h0);
      check("irq_thresh0", {63'd0, irq}, 64'h0);
      rd(A_STATUS, 64'h0802, "status_full_noirq");
      wr(A_CTRL, 64'h0);
      rd(A_STATUS, 64'h0802, "ctrl_zero_noop");
      rd(A_CTRL, 64'h0, "ctrl_rd");
      wr(A_THRESH, 64'hFF5);
      rd(A_THRESH, 64'h5, "thresh_trunc");
      wr(A_CTRL, 64'h1);
      rd(A_STATUS, 64'h1, "status_ctrl_clear");

      // decode: deselected access and unused offset
      s_sel  = 1'b0;
      s_wr   = 1'b1;
      s_addr = 16'h0200;
      s_din  = 64'hDEAD;
      @(negedge clk);
      check("desel_dout", s_dout, 64'h0);
      @(posedge clk);
      #1;
      s_wr   = 1'b0;
      s_addr = '0;
      s_din  = '0;
      rd(A_STATUS, 64'h1, "desel_no_push");
      rd(16'h0105, 64'h0, "offset5");

      // reset wins over a concurrent write
      for (int i = 0; i < 4; i++) wr(A_DATA, 64'(128 + i));
      rd(A_STATUS, 64'h0400, "status_4");
      reset_n = 1'b0;
      wr(A_DATA, 64'h99);
      reset_n = 1'b1;
      rd(A_STATUS, 64'h1, "status_post_reset");
      check("irq_post_reset", {63'd0, irq}, 64'h0);
      rd(A_THRESH, 64'h8, "thresh_post_reset");
      wr(A_DATA, 64'h77);
      rd(A_DATA, 64'h77, "pop_post_reset");
      rd(A_STATUS, 64'h1, "status_final");

      @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_fifo_slave.md
Name: bus_fifo_slave

Overview:
- Memory-mapped FIFO slave on the downstream side of the system bus. It sits in the 0x01xx window, so the bus asserts s_sel when m_addr[15:8]==8'h01.
- Master writes push 64-bit words and master reads pop them. A small register map exposes status, clear, error counters and a fill-level threshold interrupt.
- s_dout is combinational from current state, so read data returns in the same cycle as the access. All state updates on the clk rising edge.

Parameters:
- DEPTH, 8: FIFO entries. Must be a power of 2, minimum 2.
- AW, 3: pointer width, log2(DEPTH).
- DW, 64: data width; matches the bus data path.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- s_sel  in  1  slave select from bus address decode
- s_wr  in  1  1=write, 0=read; qualified by s_sel
- s_addr  in  16  slave address; only [7:0] decoded, [15:8] ignored
- s_din  in  DW  write data
- s_dout  out  DW  read data to bus
- irq  out  1  level interrupt, fill level reached threshold

Behaviour:
- Reset (reset_n==0 at posedge): rd_ptr=0, wr_ptr=0, count=0, ovf_cnt=0, udf_cnt=0, thresh=DEPTH.
  - Storage array is not cleared.
  - irq=0 after reset. s_dout=0 whenever s_sel=0.
  - Reset wins over any access in the same cycle.
- Access: every cycle with s_sel=1 is exactly one access. No wait states.
  - Writes take effect at the next posedge.
  - Read side effects (pop, counter increment) occur at the posedge ending the read cycle.
  - s_sel=0: no state change.
- Register map (offset = s_addr[7:0]; unused read bits are 0):
  - 0x00 DATA
    - Write: push s_din at wr_ptr; wr_ptr+1 mod DEPTH; count+1.
    - Read: s_dout=mem[rd_ptr]; pop; rd_ptr+1 mod DEPTH; count-1.
  - 0x01 STATUS (RO): [0]=empty, [1]=full, [2]=irq, [15:8]=count zero-extended. Writes ignored.
  - 0x02 CTRL
    - Write with s_din[0]=1: rd_ptr=wr_ptr=0, count=0. ovf_cnt, udf_cnt and thresh are unaffected.
    - Write with s_din[0]=0: no effect. Read returns 0.
  - 0x03 ERR: read returns [7:0]=ovf_cnt, [15:8]=udf_cnt. Any write clears both counters.
  - 0x04 THRESH: R/W, [AW:0] only; higher write bits discarded.
  - Other offsets: read 0, write ignored.
- Flags: empty = (count==0), full = (count==DEPTH). count is AW+1 bits, range 0..DEPTH.
- Boundaries:
  - Push when full: data dropped, pointers and count unchanged, ovf_cnt+1 saturating at 255.
  - Pop when empty: s_dout=0, pointers unchanged, udf_cnt+1 saturating at 255.
  - Pointer wrap from DEPTH-1 to 0 is seamless. Data order is strictly FIFO across the wrap.
  - Full/empty are never simultaneously true.
- irq = (thresh!=0) && (count>=thresh). Registered: reflects count/thresh after the posedge, no extra delay. Level only; it stays high until count drops below thresh or thresh is set to 0.
- Reset mid-operation: all pointer, count and counter state is lost on the reset cycle. The first access after reset sees an empty FIFO.

Test Plan:
- Reset, read STATUS (addr 0x0101) -> s_dout=64'h1 (empty=1, count=0); irq=0.
- Push 64'hA1, 64'hB2, 64'hC3; read STATUS -> 64'h0300. Read DATA three times -> A1, B2, C3 in order; final STATUS -> 64'h1.
- Push 9 words 1..9 with DEPTH=8:
  - STATUS -> 64'h0802 (full=1).
  - ERR -> 64'h01; word 9 lost.
  - Pop 8 -> 1..8.
  - Pop once more -> s_dout=0, ERR -> 64'h0101.
  - Write ERR -> ERR reads 0.
- Wrap: push 6, pop 6, push 5 values 10..14 (wr_ptr wraps past 7) -> pops return 10..14 in order; count 0 at end.
- Threshold and clear:
  - Write THRESH=3, push 2 -> irq=0; 3rd push -> irq=1 the cycle after the push edge.
  - Write CTRL=1 -> count=0, irq=0, THRESH still reads 3.
  - Write THRESH=0 with 8 entries -> irq=0.
- Decode and reset priority:
  - Access with s_sel=0 (addr 0x0200, write) -> no state change, s_dout=0.
  - Offset 0x05 read -> 0.
  - reset_n=0 during a DATA write with 4 entries -> next STATUS=64'h1, pushed word absent.
